// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the EX/MEM register, the MEM stage and the MEM/WB register.
interface mem_wb_stage_if;
  logic [31:0] IR_M;
  logic [31:0] PC4_M;
  logic [31:0] AO_M;
  logic [31:0] RT_M;
  logic        Fwd_RT;
  logic [31:0] WD_W;
  logic [31:0] IR_W;
  logic [31:0] PC4_W;
  logic [31:0] AO_W;
  logic [31:0] DR_W;
  logic        AdE_W;

  // Upstream side: drives the M-stage bundle and observes the W-stage bundle.
  modport master (
    output IR_M, PC4_M, AO_M, RT_M, Fwd_RT, WD_W,
    input  IR_W, PC4_W, AO_W, DR_W, AdE_W
  );

  // The stage itself.
  modport slave (
    input  IR_M, PC4_M, AO_M, RT_M, Fwd_RT, WD_W,
    output IR_W, PC4_W, AO_W, DR_W, AdE_W
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS MEM stage: data memory with byte-lane stores, extended loads,
// address-error detection and the MEM/WB pipeline register.
module mem_wb_stage #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic           Clk,
  input  logic           Reset,
  mem_wb_stage_if.slave  bus
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] mem [DEPTH];

  logic [5:0]        opcode;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        off;
  logic              is_load, is_store, load_signed;
  logic              acc_word, acc_half, acc_byte;
  logic              out_range, misaligned, err;
  logic [31:0]       store_data;
  logic [3:0]        be;
  logic [3:0]        wr_en;
  logic [7:0]        wr_lane [4];
  logic [31:0]       rd_word;
  logic [7:0]        rd_lane [4];
  logic [15:0]       rd_half;
  logic [7:0]        rd_byte;
  logic [31:0]       dr_next;

  logic [31:0] ir_reg, pc4_reg, ao_reg, dr_reg;
  logic        ade_reg;

  assign opcode     = bus.IR_M[31:26];
  assign widx       = bus.AO_M[ADDR_W+1:2];
  assign off        = bus.AO_M[1:0];
  assign store_data = bus.Fwd_RT ? bus.WD_W : bus.RT_M;

  // Opcode decode into access class, width and signedness.
  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    load_signed = 1'b0;
    acc_word    = 1'b0;
    acc_half    = 1'b0;
    acc_byte    = 1'b0;
    case (opcode)
      OP_LW:  begin is_load = 1'b1; acc_word = 1'b1; end
      OP_LH:  begin is_load = 1'b1; acc_half = 1'b1; load_signed = 1'b1; end
      OP_LHU: begin is_load = 1'b1; acc_half = 1'b1; end
      OP_LB:  begin is_load = 1'b1; acc_byte = 1'b1; load_signed = 1'b1; end
      OP_LBU: begin is_load = 1'b1; acc_byte = 1'b1; end
      OP_SW:  begin is_store = 1'b1; acc_word = 1'b1; end
      OP_SH:  begin is_store = 1'b1; acc_half = 1'b1; end
      OP_SB:  begin is_store = 1'b1; acc_byte = 1'b1; end
      default: ;
    endcase
  end

  // Any nonzero bit above the word index means the address falls outside the array,
  // so out-of-range addresses never alias onto a real word.
  assign out_range  = |bus.AO_M[31:ADDR_W+2];
  assign misaligned = (acc_word && (off != 2'b00)) || (acc_half && off[0]);
  assign err        = (is_load || is_store) && (misaligned || out_range);

  // Byte enables for the store; the lane data is replicated so each lane picks its own byte.
  always_comb begin
    be = 4'b0000;
    if (acc_word)      be = 4'b1111;
    else if (acc_half) be = off[1] ? 4'b1100 : 4'b0011;
    else if (acc_byte) be = 4'b0001 << off;
  end

  assign wr_en = be & {4{is_store && !err}};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_lane[gi] = acc_word ? store_data[8*gi +: 8] :
                           acc_half ? store_data[8*(gi%2) +: 8] :
                                      store_data[7:0];
      assign rd_lane[gi] = rd_word[8*gi +: 8];
    end
  endgenerate

  // Data array: cleared asynchronously while reset is low, byte-lane writes otherwise.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_en[b]) mem[widx][8*b +: 8] <= wr_lane[b];
      end
    end
  end

  assign rd_word = mem[widx];
  assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];
  assign rd_byte = rd_lane[off];

  // Load extraction and extension; non-loads and faulting loads return zero.
  always_comb begin
    dr_next = '0;
    if (is_load && !err) begin
      if (acc_word)
        dr_next = rd_word;
      else if (acc_half)
        dr_next = load_signed ? {{16{rd_half[15]}}, rd_half} : {16'h0000, rd_half};
      else
        dr_next = load_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'h000000, rd_byte};
    end
  end

  // MEM/WB register: captures every cycle, no stall or flush.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ir_reg  <= '0;
      pc4_reg <= '0;
      ao_reg  <= '0;
      dr_reg  <= '0;
      ade_reg <= 1'b0;
    end else begin
      ir_reg  <= bus.IR_M;
      pc4_reg <= bus.PC4_M;
      ao_reg  <= bus.AO_M;
      dr_reg  <= dr_next;
      ade_reg <= err;
    end
  end

  assign bus.IR_W  = ir_reg;
  assign bus.PC4_W = pc4_reg;
  assign bus.AO_W  = ao_reg;
  assign bus.DR_W  = dr_reg;
  assign bus.AdE_W = ade_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, asynchronous reset sequences,
// and random traffic against a byte-addressed reference memory.
module tb_mem_wb_stage;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam int MEM_BYTES = 4096;

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic [31:0] ao;
    logic [31:0] rt;
    logic [31:0] wd;
    logic        fwd;
    logic        chk_dr;
    logic [31:0] dr;
    logic        ade;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc = 32'h0000_3000;
  vec_t        tbl[$];
  logic [7:0]  model [MEM_BYTES];

  mem_wb_stage_if bus();

  mem_wb_stage #(.DEPTH(1024), .ADDR_W(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string tag, input logic [5:0] op, input logic [31:0] ao,
                              input logic [31:0] rt, input logic [31:0] wd, input logic fwd,
                              input logic chk_dr, input logic [31:0] dr, input logic ade);
    vec_t v;
    v.tag = tag; v.op = op; v.ao = ao; v.rt = rt; v.wd = wd; v.fwd = fwd;
    v.chk_dr = chk_dr; v.dr = dr; v.ade = ade;
    return v;
  endfunction

  // One instruction through M, then check the W bundle 1 time unit after the capturing edge.
  task automatic apply(input string tag, input logic [5:0] op, input logic [31:0] ao,
                       input logic [31:0] rt, input logic [31:0] wd, input logic fwd,
                       input logic chk_dr, input logic [31:0] exp_dr, input logic exp_ade);
    logic [31:0] ir;
    @(negedge Clk);
    ir = {op, 26'($urandom)};
    pc = pc + 32'd4;
    bus.IR_M   = ir;
    bus.PC4_M  = pc;
    bus.AO_M   = ao;
    bus.RT_M   = rt;
    bus.WD_W   = wd;
    bus.Fwd_RT = fwd;
    @(posedge Clk);
    #1;
    chk({tag, ".ir"},  bus.IR_W,  ir);
    chk({tag, ".pc4"}, bus.PC4_W, pc);
    chk({tag, ".ao"},  bus.AO_W,  ao);
    if (chk_dr) chk({tag, ".dr"}, bus.DR_W, exp_dr);
    chk({tag, ".ade"}, {31'b0, bus.AdE_W}, {31'b0, exp_ade});
    $display("txn %s op=%b ao=%h rt=%h fwd=%b dr=%h ade=%b", tag, op, ao, rt, fwd, bus.DR_W, bus.AdE_W);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".ir"},  bus.IR_W,  32'h0);
    chk({tag, ".pc4"}, bus.PC4_W, 32'h0);
    chk({tag, ".ao"},  bus.AO_W,  32'h0);
    chk({tag, ".dr"},  bus.DR_W,  32'h0);
    chk({tag, ".ade"}, {31'b0, bus.AdE_W}, 32'h0);
  endtask

  function automatic int size_of(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:          return 4;
      OP_LH, OP_LHU, OP_SH:  return 2;
      OP_LB, OP_LBU, OP_SB:  return 1;
      default:               return 0;
    endcase
  endfunction

  function automatic bit is_store_op(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Reference behaviour: byte-addressed memory, little-endian assembly, arithmetic checks.
  task automatic model_step(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] sd,
                            output logic chk_dr, output logic [31:0] exp_dr, output logic exp_ade);
    int          sz;
    bit          bad;
    logic [31:0] v;
    sz      = size_of(op);
    bad     = (sz != 0) && ((ao >= MEM_BYTES) || ((ao % sz) != 0));
    exp_ade = bad;
    exp_dr  = 32'h0;
    chk_dr  = !is_store_op(op);
    if (sz != 0 && !bad) begin
      if (is_store_op(op)) begin
        for (int i = 0; i < sz; i++) model[int'(ao) + i] = sd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(model[int'(ao) + i]) << (8 * i));
        if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
        if (op == OP_LB && v[7])  v = v | 32'hFFFF_FF00;
        exp_dr = v;
      end
    end
  endtask

  initial begin
    logic [5:0]  ops [10];
    logic [5:0]  op;
    logic [31:0] ao, rt, wd, sd, exp_dr;
    logic        fwd, chk_dr, exp_ade;
    int          r;

    // Reset held with clock running and a store presented: nothing may be written.
    Reset      = 1'b0;
    bus.IR_M   = {OP_SW, 26'h0};
    bus.PC4_M  = 32'h100;
    bus.AO_M   = 32'h0;
    bus.RT_M   = 32'hFFFF_FFFF;
    bus.WD_W   = 32'h0;
    bus.Fwd_RT = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk_zero_outputs("rst");
    @(negedge Clk);
    Reset    = 1'b1;
    bus.IR_M = 32'h0;

    tbl.push_back(mk("lw0",      OP_LW,  32'h0,    32'h0,        32'h0,        0, 1, 32'h0000_0000, 0));
    tbl.push_back(mk("sw10",     OP_SW,  32'h10,   32'h1234_5678, 32'h0,       0, 0, 32'h0,         0));
    tbl.push_back(mk("lw10",     OP_LW,  32'h10,   32'h0,        32'h0,        0, 1, 32'h1234_5678, 0));
    tbl.push_back(mk("lb13",     OP_LB,  32'h13,   32'h0,        32'h0,        0, 1, 32'h0000_0012, 0));
    tbl.push_back(mk("lb10",     OP_LB,  32'h10,   32'h0,        32'h0,        0, 1, 32'h0000_0078, 0));
    tbl.push_back(mk("sb21",     OP_SB,  32'h21,   32'h0000_0080, 32'h0,       0, 0, 32'h0,         0));
    tbl.push_back(mk("lb21",     OP_LB,  32'h21,   32'h0,        32'h0,        0, 1, 32'hFFFF_FF80, 0));
    tbl.push_back(mk("lbu21",    OP_LBU, 32'h21,   32'h0,        32'h0,        0, 1, 32'h0000_0080, 0));
    tbl.push_back(mk("lw20",     OP_LW,  32'h20,   32'h0,        32'h0,        0, 1, 32'h0000_8000, 0));
    tbl.push_back(mk("sh32",     OP_SH,  32'h32,   32'h0000_BEEF, 32'h0,       0, 0, 32'h0,         0));
    tbl.push_back(mk("lh32",     OP_LH,  32'h32,   32'h0,        32'h0,        0, 1, 32'hFFFF_BEEF, 0));
    tbl.push_back(mk("lhu32",    OP_LHU, 32'h32,   32'h0,        32'h0,        0, 1, 32'h0000_BEEF, 0));
    tbl.push_back(mk("lw30",     OP_LW,  32'h30,   32'h0,        32'h0,        0, 1, 32'hBEEF_0000, 0));
    tbl.push_back(mk("lh30",     OP_LH,  32'h30,   32'h0,        32'h0,        0, 1, 32'h0000_0000, 0));
    tbl.push_back(mk("sw40",     OP_SW,  32'h40,   32'hA5A5_A5A5, 32'h0,       0, 0, 32'h0,         0));
    tbl.push_back(mk("sw41mis",  OP_SW,  32'h41,   32'hFFFF_FFFF, 32'h0,       0, 0, 32'h0,         1));
    tbl.push_back(mk("lw40",     OP_LW,  32'h40,   32'h0,        32'h0,        0, 1, 32'hA5A5_A5A5, 0));
    tbl.push_back(mk("lw1000",   OP_LW,  32'h1000, 32'h0,        32'h0,        0, 1, 32'h0,         1));
    tbl.push_back(mk("lw40b",    OP_LW,  32'h40,   32'h0,        32'h0,        0, 1, 32'hA5A5_A5A5, 0));
    tbl.push_back(mk("sb1021",   OP_SB,  32'h1021, 32'h0000_00FF, 32'h0,       0, 0, 32'h0,         1));
    tbl.push_back(mk("lw20b",    OP_LW,  32'h20,   32'h0,        32'h0,        0, 1, 32'h0000_8000, 0));
    tbl.push_back(mk("swfwd8",   OP_SW,  32'h8,    32'h1111_1111, 32'hCAFE_F00D, 1, 0, 32'h0,       0));
    tbl.push_back(mk("lw8",      OP_LW,  32'h8,    32'h0,        32'h0,        0, 1, 32'hCAFE_F00D, 0));
    tbl.push_back(mk("lh33mis",  OP_LH,  32'h33,   32'h0,        32'h0,        0, 1, 32'h0,         1));
    tbl.push_back(mk("lw42mis",  OP_LW,  32'h42,   32'h0,        32'h0,        0, 1, 32'h0,         1));
    tbl.push_back(mk("lb43",     OP_LB,  32'h43,   32'h0,        32'h0,        0, 1, 32'hFFFF_FFA5, 0));
    tbl.push_back(mk("addi_hi",  OP_ADDI, 32'hFFFF_0001, 32'h0,  32'h0,        0, 1, 32'h0,         0));
    tbl.push_back(mk("bubble",   6'b000000, 32'h10, 32'h0,       32'h0,        0, 1, 32'h0,         0));

    foreach (tbl[i])
      apply(tbl[i].tag, tbl[i].op, tbl[i].ao, tbl[i].rt, tbl[i].wd, tbl[i].fwd,
            tbl[i].chk_dr, tbl[i].dr, tbl[i].ade);

    // Reset asserted between edges: outputs clear without a clock edge.
    apply("mr.sw50", OP_SW, 32'h50, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    chk_zero_outputs("mr.async");
    // A store presented while reset is low is lost.
    @(negedge Clk);
    bus.IR_M = {OP_SW, 26'h0};
    bus.AO_M = 32'h60;
    bus.RT_M = 32'h5555_AAAA;
    @(posedge Clk);
    @(negedge Clk);
    Reset    = 1'b1;
    bus.IR_M = 32'h0;
    apply("mr.lw50", OP_LW, 32'h50, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    apply("mr.lw60", OP_LW, 32'h60, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    apply("mr.lw10", OP_LW, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    apply("mr.lw8",  OP_LW, 32'h8,  32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

    // Random traffic; memory is known to be all-zero after the reset above.
    for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
    ops[0] = OP_LW; ops[1] = OP_LH; ops[2] = OP_LHU; ops[3] = OP_LB; ops[4] = OP_LBU;
    ops[5] = OP_SW; ops[6] = OP_SH; ops[7] = OP_SB;  ops[8] = OP_ADDI; ops[9] = 6'b000000;
    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 9)];
      r  = $urandom_range(0, 9);
      if (r < 8)       ao = 32'($urandom_range(0, 63));
      else if (r == 8) ao = 32'($urandom_range(0, MEM_BYTES - 1));
      else             ao = $urandom | 32'h0000_1000;
      rt  = $urandom;
      wd  = $urandom;
      fwd = 1'($urandom_range(0, 1));
      sd  = fwd ? wd : rt;
      model_step(op, ao, sd, chk_dr, exp_dr, exp_ade);
      apply($sformatf("rnd%0d", n), op, ao, rt, wd, fwd, chk_dr, exp_dr, exp_ade);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register.
- Takes the MEM-stage instruction bundle (IR, PC+4, ALU result, rt data) and performs word, halfword and byte stores into an internal data memory.
- Extends load data and registers the WB bundle (MEM/WB register) that feeds register-file write-back.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH, 1024, data memory size in 32-bit words (power of two).
- ADDR_W, 10, word-index width, log2(DEPTH).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous active-low reset (0 = reset).
- IR_M  input  32  MEM-stage instruction.
- PC4_M  input  32  MEM-stage PC+4.
- AO_M  input  32  ALU result, used as byte address.
- RT_M  input  32  rt value from EX/MEM register.
- Fwd_RT  input  1  1 = use WD_W as store data (W→M forward).
- WD_W  input  32  current write-back data.
- IR_W  output  32  registered instruction.
- PC4_W  output  32  registered PC+4.
- AO_W  output  32  registered ALU result.
- DR_W  output  32  registered, extended load data.
- AdE_W  output  1  registered address-error flag for the instruction now in W.

Behaviour:
- Reset low (async): IR_W, PC4_W, AO_W, DR_W = 0; AdE_W = 0; every memory word cleared to 0 while Reset is held low. No writes while Reset is low.
- Decode IR_M[31:26]:
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - sw 101011, sh 101001, sb 101000.
  - Any other opcode: no memory access, DR_W = 0.
- Store data: SD = Fwd_RT ? WD_W : RT_M.
- Addressing: word index = AO_M[ADDR_W+1:2]; byte offset = AO_M[1:0].
- Range check: out of range when AO_M[31:ADDR_W+2] != 0.
- Alignment check:
  - Word access is misaligned when AO_M[1:0] != 0.
  - Halfword access is misaligned when AO_M[0] != 0.
  - Byte access is never misaligned.
- Error: err = (load or store) and (misaligned or out of range).
  - Error store is suppressed; memory is unchanged.
  - Error load gives DR_W = 0.
  - AdE_W = err, registered.
- Store commit at the rising edge ending the cycle the store is in M, with byte enables:
  - sw: all 4 bytes ← SD.
  - sh: bytes {off+1, off} ← SD[15:0].
  - sb: byte off ← SD[7:0].
  - Byte 0 = bits [7:0] (little-endian lanes); untouched lanes are kept.
- Load read is combinational from the array; the result is captured into DR_W at the same edge:
  - lw: full word.
  - lh / lhu: halfword at AO_M[1] (0 → [15:0], 1 → [31:16]), sign- or zero-extended.
  - lb / lbu: byte lane AO_M[1:0], sign- or zero-extended.
- Latency:
  - IR/PC4/AO/DR/AdE visible at W one cycle after the instruction is in M.
  - A store in cycle N is visible to a load in M in cycle N+1 (read-after-write through memory, no bypass needed).
- No stall or flush inputs: the register captures every cycle; a bubble is IR_M = 0 and produces no access.
- Reset asserted mid-store: the write is lost; the array and registers are zeroed immediately, without waiting for Clk.
- Reset deasserted: first capture at the next rising edge.

Test Plan:
- Hold Reset=0 with Clk running, then release → all outputs 0; lw from address 0x0 gives DR_W=0x00000000.
- sw RT_M=0x12345678 @0x10, then lw @0x10 → DR_W=0x12345678 one cycle after the lw is in M; lb @0x13 → 0x00000012; lb @0x10 → 0x00000078.
- sb 0x80 @0x21 over word 0 → lb @0x21 = 0xFFFFFF80, lbu @0x21 = 0x00000080, lw @0x20 = 0x00008000.
- sh RT_M=0xBEEF @0x32 → lh @0x32 = 0xFFFFBEEF, lhu @0x32 = 0x0000BEEF, lw @0x30 = 0xBEEF0000.
- sw @0x41 (misaligned) → word @0x40 unchanged, AdE_W=1; lw @0x1000 (DEPTH 1024) → DR_W=0, AdE_W=1; next legal access gives AdE_W=0.
- sw with Fwd_RT=1, RT_M=0x11111111, WD_W=0xCAFEF00D @0x8 → lw @0x8 = 0xCAFEF00D.
- Assert Reset low between edges mid-sequence → outputs 0 with no clock edge, and memory reads 0 after release.
